// File: rtl/code_run_encoder.sv
// Run-length encoder for the 2-bit code stream: (code, run) pairs, 1-cycle latency, valid/ready both sides.
// Optional macro CODE_XZ_TRAP_EN: x/z input codes are dropped and flagged on the sticky xz_err output.
module code_run_encoder #(
  parameter int RUN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_code,
  output logic [RUN_W-1:0] out_run,
  output logic             busy,
  output logic             xz_err
);

  localparam logic [RUN_W-1:0] MAX  = '1;
  localparam logic [RUN_W-1:0] LAST = MAX - 1'b1;
  localparam logic [RUN_W-1:0] ONE  = {{(RUN_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state, state_nxt;
  logic [1:0]       cur_code, code_nxt;
  logic [RUN_W-1:0] cur_len, len_nxt;
  logic             load, out_free, accept, drop, take;
  logic [1:0]       ld_code;
  logic [RUN_W-1:0] ld_run;

  assign out_free = !out_valid || out_ready;
  assign in_ready = !flush && out_free;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ACCUM) || out_valid;

`ifdef CODE_XZ_TRAP_EN
  assign drop = accept && $isunknown(in_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xz_err <= 1'b0;
    end else if (drop) begin
      xz_err <= 1'b1;
`ifndef SYNTHESIS
      $display("code_run_encoder: unknown code %b dropped at time %0t", in_code, $time);
`endif
    end
  end
`else
  assign drop   = 1'b0;
  assign xz_err = 1'b0;
`endif

  assign take = accept && !drop;

  always_comb begin
    state_nxt = state;
    code_nxt  = cur_code;
    len_nxt   = cur_len;
    load      = 1'b0;
    ld_code   = cur_code;
    ld_run    = cur_len;
    case (state)
      IDLE: begin
        if (take) begin
          code_nxt  = in_code;
          len_nxt   = ONE;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (take) begin
          // 4-state compare so x/z codes extend runs only on an exact match
          if (in_code === cur_code) begin
            if (cur_len == LAST) begin
              load      = 1'b1;
              ld_run    = MAX;
              len_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              len_nxt = cur_len + 1'b1;
            end
          end else begin
            load     = 1'b1;
            code_nxt = in_code;
            len_nxt  = ONE;
          end
        end else if (flush && out_free) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_code <= 2'b00;
      cur_len  <= '0;
    end else begin
      state    <= state_nxt;
      cur_code <= code_nxt;
      cur_len  <= len_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_code  <= 2'b00;
      out_run   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_code  <= ld_code;
      out_run   <= ld_run;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
